// File: rtl/match_timer_if.sv
// Control and status bundle for match_timer: game-side controls in, time and flags out.
interface match_timer_if #(
    parameter int SEC_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic                  pause;
    logic                  restart;
    logic [SEC_W-1:0]      seconds_left;
    logic [4*DIGITS-1:0]   bcd;
    logic                  running;
    logic                  warn;
    logic                  time_over;
    logic                  time_over_pulse;
    logic                  overtime;

    modport master (
        output start, pause, restart,
        input  seconds_left, bcd, running, warn, time_over, time_over_pulse, overtime
    );

    modport slave (
        input  start, pause, restart,
        output seconds_left, bcd, running, warn, time_over, time_over_pulse, overtime
    );
endinterface

// File: rtl/match_timer.sv
// Match clock: counts MATCH_SECONDS down in binary and packed BCD off a clk25 prescaler.
// Optional overtime count-up is enabled by defining MATCH_TIMER_OVERTIME_EN.
module match_timer #(
    parameter int TICK_DIV      = 25000000,
    parameter int MATCH_SECONDS = 180,
    parameter int SEC_W         = 8,
    parameter int DIGITS        = 3,
    parameter int WARN_SECONDS  = 10
) (
    input  logic         clk25,
    input  logic         reset,
    match_timer_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = 4 * DIGITS;

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Borrow ripples up through digits that are already 0.
    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic          brw;
        r   = b;
        brw = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (brw) begin
                if (b[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = b[4*i +: 4] - 4'd1;
                    brw = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [BW-1:0]    BCD_INIT = to_bcd(MATCH_SECONDS);
    localparam logic [SEC_W-1:0] SEC_INIT = SEC_W'(MATCH_SECONDS);
    localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);

`ifdef MATCH_TIMER_OVERTIME_EN
    localparam int SEC_MAX = (2 ** SEC_W) - 1;
    localparam int BCD_MAX = (10 ** DIGITS) - 1;
    localparam int OT_MAX  = (SEC_MAX < BCD_MAX) ? SEC_MAX : BCD_MAX;

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic          cy;
        r  = b;
        cy = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (b[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = b[4*i +: 4] + 4'd1;
                    cy = 1'b0;
                end
            end
        end
        return r;
    endfunction
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_OVER
`ifdef MATCH_TIMER_OVERTIME_EN
        ,
        S_OT,
        S_OT_PAUSED
`endif
    } state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    pre, pre_nx;
    logic [SEC_W-1:0] sec, sec_nx;
    logic [BW-1:0]    bcd, bcd_nx;
    logic             pulse_nx, running_nx, over_nx, ot_nx, warn_nx;
    logic             running_q, over_q, ot_q, warn_q, pulse_q;
    logic             tick, go;

    assign tick = (pre == PRE_LAST);
    // pause outranks start, so a simultaneous pair never resumes.
    assign go   = bus.start && !bus.pause;

    always_comb begin
        state_nx = state;
        pre_nx   = pre;
        sec_nx   = sec;
        bcd_nx   = bcd;
        pulse_nx = 1'b0;
        if (bus.restart) begin
            state_nx = S_IDLE;
            pre_nx   = '0;
            sec_nx   = SEC_INIT;
            bcd_nx   = BCD_INIT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state_nx = S_RUN;
                        pre_nx   = '0;
                    end
                end
                S_RUN: begin
                    pre_nx = tick ? '0 : pre + PW'(1);
                    if (tick && sec == SEC_W'(1)) begin
                        state_nx = S_OVER;
                        sec_nx   = '0;
                        bcd_nx   = '0;
                        pulse_nx = 1'b1;
                    end else begin
                        if (tick) begin
                            sec_nx = sec - SEC_W'(1);
                            bcd_nx = bcd_dec(bcd);
                        end
                        if (bus.pause) state_nx = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (go) state_nx = S_RUN;
                end
`ifdef MATCH_TIMER_OVERTIME_EN
                S_OVER: begin
                    if (go) begin
                        state_nx = S_OT;
                        pre_nx   = '0;
                    end
                end
                S_OT: begin
                    pre_nx = tick ? '0 : pre + PW'(1);
                    if (tick && int'(sec) < OT_MAX) begin
                        sec_nx = sec + SEC_W'(1);
                        bcd_nx = bcd_inc(bcd);
                    end
                    if (bus.pause) state_nx = S_OT_PAUSED;
                end
                S_OT_PAUSED: begin
                    if (go) state_nx = S_OT;
                end
`else
                S_OVER: ;
`endif
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Flags are decoded from the next state so they land on the same edge as the state.
    always_comb begin
        running_nx = 1'b0;
        over_nx    = 1'b0;
        ot_nx      = 1'b0;
        case (state_nx)
            S_RUN:       running_nx = 1'b1;
            S_OVER:      over_nx    = 1'b1;
`ifdef MATCH_TIMER_OVERTIME_EN
            S_OT: begin
                running_nx = 1'b1;
                over_nx    = 1'b1;
                ot_nx      = 1'b1;
            end
            S_OT_PAUSED: begin
                over_nx = 1'b1;
                ot_nx   = 1'b1;
            end
`endif
            default: ;
        endcase
        // Uses the current count, giving warn its one-cycle lag behind seconds_left.
        warn_nx = (state_nx == S_RUN) && (sec != '0) && (int'(sec) <= WARN_SECONDS);
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pre       <= '0;
            sec       <= SEC_INIT;
            bcd       <= BCD_INIT;
            running_q <= 1'b0;
            over_q    <= 1'b0;
            ot_q      <= 1'b0;
            warn_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            pre       <= pre_nx;
            sec       <= sec_nx;
            bcd       <= bcd_nx;
            running_q <= running_nx;
            over_q    <= over_nx;
            ot_q      <= ot_nx;
            warn_q    <= warn_nx;
            pulse_q   <= pulse_nx;
        end
    end

    assign bus.seconds_left    = sec;
    assign bus.bcd             = bcd;
    assign bus.running         = running_q;
    assign bus.warn            = warn_q;
    assign bus.time_over       = over_q;
    assign bus.time_over_pulse = pulse_q;
`ifdef MATCH_TIMER_OVERTIME_EN
    assign bus.overtime        = ot_q;
`else
    assign bus.overtime        = 1'b0;
`endif
endmodule

// File: tb/tb_match_timer.sv
// Directed bench for match_timer with TICK_DIV=4, MATCH_SECONDS=12, WARN_SECONDS=10.
module tb_match_timer;
    logic clk25;
    logic reset;
    int   errors;
    int   checks;

    match_timer_if #(.SEC_W(8), .DIGITS(3)) bus ();

    match_timer #(
        .TICK_DIV(4), .MATCH_SECONDS(12), .SEC_W(8), .DIGITS(3), .WARN_SECONDS(10)
    ) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk25);
    endtask

    function automatic int bcd_of(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    int  exp_sec;
    logic moved;

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.restart = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        chk("rst_sec", 32'(bus.seconds_left), 12);
        chk("rst_bcd", 32'(bus.bcd), 32'h012);
        chk("rst_flags", {27'd0, bus.running, bus.warn, bus.time_over,
                          bus.time_over_pulse, bus.overtime}, 0);

        moved = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.seconds_left != 8'd12 || bus.running || bus.time_over) moved = 1'b1;
        end
        chk("idle_hold", 32'(moved), 0);

        // Full match: start edge, then one decrement every 4 cycles.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_run", 32'(bus.running), 1);
        for (int c = 1; c <= 48; c++) begin
            step();
            exp_sec = 12 - c / 4;
            chk("run_sec", 32'(bus.seconds_left), 32'(exp_sec));
            chk("run_bcd", 32'(bus.bcd), 32'(bcd_of(exp_sec)));
            chk("run_running", 32'(bus.running), 32'(c < 48));
            chk("run_pulse", 32'(bus.time_over_pulse), 32'(c == 48));
            chk("run_tover", 32'(bus.time_over), 32'(c == 48));
            chk("run_warn", 32'(bus.warn), 32'(c >= 9 && c <= 47));
        end
        repeat (5) step();
        chk("over_sec", 32'(bus.seconds_left), 0);
        chk("over_pulse", 32'(bus.time_over_pulse), 0);
        chk("over_level", 32'(bus.time_over), 1);

`ifdef MATCH_TIMER_OVERTIME_EN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ot_flag", 32'(bus.overtime), 1);
        chk("ot_running", 32'(bus.running), 1);
        chk("ot_tover", 32'(bus.time_over), 1);
        chk("ot_sec0", 32'(bus.seconds_left), 0);
        for (int k = 1; k <= 10; k++) begin
            repeat (4) step();
            chk("ot_sec", 32'(bus.seconds_left), 32'(k));
            chk("ot_bcd", 32'(bus.bcd), 32'(bcd_of(k)));
        end
        repeat ((255 - 10) * 4) step();
        chk("ot_top", 32'(bus.seconds_left), 255);
        chk("ot_top_bcd", 32'(bus.bcd), 32'h255);
        repeat (8) step();
        chk("ot_sat", 32'(bus.seconds_left), 255);
        chk("ot_sat_bcd", 32'(bus.bcd), 32'h255);
`else
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("over_start_sec", 32'(bus.seconds_left), 0);
        chk("over_start_run", 32'(bus.running), 0);
        chk("over_start_ot", 32'(bus.overtime), 0);
        chk("over_start_lvl", 32'(bus.time_over), 1);
`endif

        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("rs_sec", 32'(bus.seconds_left), 12);
        chk("rs_bcd", 32'(bus.bcd), 32'h012);
        chk("rs_flags", {28'd0, bus.running, bus.time_over, bus.overtime, bus.warn}, 0);

        // Pause two cycles after a tick; resume must finish the frozen prescaler.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        chk("p_tick", 32'(bus.seconds_left), 11);
        step();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        chk("p_running", 32'(bus.running), 0);
        repeat (20) step();
        chk("p_hold", 32'(bus.seconds_left), 11);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("r_running", 32'(bus.running), 1);
        chk("r_sec0", 32'(bus.seconds_left), 11);
        step();
        chk("r_sec1", 32'(bus.seconds_left), 11);
        step();
        chk("r_sec2", 32'(bus.seconds_left), 10);

        bus.start = 1'b1;
        bus.pause = 1'b1;
        step();
        bus.start = 1'b0;
        bus.pause = 1'b0;
        chk("sp_paused", 32'(bus.running), 0);
        repeat (8) step();
        chk("sp_hold", 32'(bus.seconds_left), 10);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        bus.restart = 1'b1;
        bus.start = 1'b1;
        step();
        bus.restart = 1'b0;
        bus.start = 1'b0;
        chk("rss_running", 32'(bus.running), 0);
        chk("rss_sec", 32'(bus.seconds_left), 12);
        chk("rss_bcd", 32'(bus.bcd), 32'h012);
        repeat (8) step();
        chk("rss_idle", 32'(bus.seconds_left), 12);

        // Reset mid-match reloads and stays idle.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();
        chk("mr_sec", 32'(bus.seconds_left), 12);
        chk("mr_running", 32'(bus.running), 0);
        chk("mr_bcd", 32'(bus.bcd), 32'h012);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
